// File: rtl/axi_lite_counter_if.sv
// rtl/axi_lite_counter_if.sv - AXI4-Lite register bus bundle for the counter block
interface axi_lite_counter_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]                      awprot;
    logic                            awvalid;
    logic                            awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                            wvalid;
    logic                            wready;
    logic [1:0]                      bresp;
    logic                            bvalid;
    logic                            bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   araddr;
    logic [2:0]                      arprot;
    logic                            arvalid;
    logic                            arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                      rresp;
    logic                            rvalid;
    logic                            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_counter.sv
// rtl/axi_lite_counter.sv - 8-bit up/down counter controlled through AXI4-Lite registers
module axi_lite_counter #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    axi_lite_counter_if.slave s_axi,
    output logic [7:0]        count_out
);
    localparam logic [1:0]  REG_CTRL    = 2'd0;
    localparam logic [1:0]  REG_START   = 2'd1;
    localparam logic [1:0]  REG_SCRATCH = 2'd2;
    localparam logic [1:0]  REG_ID      = 2'd3;
    localparam logic [31:0] ID_VALUE    = 32'hABCD_1234;

    logic [31:0] ctrl_reg;
    logic [31:0] start_reg;
    logic [31:0] scratch_reg;
    logic        awready_q;
    logic        bvalid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic        load_pending;
    logic [7:0]  load_val;
    logic [7:0]  count;

    logic        write_fire;
    logic        read_fire;
    logic [1:0]  wsel;
    logic [1:0]  rsel;
    logic [31:0] start_merged;
    logic        unused_bits;

    function automatic logic [31:0] strobe_merge(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    // awready/wready are one shared pulse, so both channels complete on the same edge
    assign write_fire   = awready_q && s_axi.awvalid && s_axi.wvalid;
    assign read_fire    = arready_q && s_axi.arvalid;
    assign wsel         = s_axi.awaddr[3:2];
    assign rsel         = s_axi.araddr[3:2];
    assign start_merged = strobe_merge(start_reg, s_axi.wdata, s_axi.wstrb);
    assign unused_bits  = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = 2'b00;
    assign count_out     = count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrl_reg     <= '0;
            start_reg    <= '0;
            scratch_reg  <= '0;
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            load_pending <= 1'b0;
            load_val     <= '0;
        end else begin
            awready_q    <= s_axi.awvalid && s_axi.wvalid && !bvalid_q && !awready_q;
            load_pending <= 1'b0;
            if (write_fire) begin
                bvalid_q <= 1'b1;
                case (wsel)
                    REG_CTRL:    ctrl_reg    <= strobe_merge(ctrl_reg, s_axi.wdata, s_axi.wstrb);
                    REG_START: begin
                        start_reg    <= start_merged;
                        load_pending <= 1'b1;
                        load_val     <= start_merged[7:0];
                    end
                    REG_SCRATCH: scratch_reg <= strobe_merge(scratch_reg, s_axi.wdata, s_axi.wstrb);
                    default:     ;
                endcase
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read data is captured at the address handshake and held until rready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= s_axi.arvalid && !rvalid_q && !arready_q;
            if (read_fire) begin
                rvalid_q <= 1'b1;
                case (rsel)
                    REG_CTRL:    rdata_q <= ctrl_reg;
                    REG_START:   rdata_q <= start_reg;
                    REG_SCRATCH: rdata_q <= scratch_reg;
                    REG_ID:      rdata_q <= ID_VALUE;
                    default:     rdata_q <= '0;
                endcase
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // A START load has priority over counting and applies even when disabled
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (load_pending) begin
            count <= load_val;
        end else if (ctrl_reg[0]) begin
            count <= ctrl_reg[1] ? count - 8'd1 : count + 8'd1;
        end
    end
endmodule

// File: tb/tb_axi_lite_counter.sv
// tb/tb_axi_lite_counter.sv - directed self-checking bench for axi_lite_counter
module tb_axi_lite_counter;
    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] count_out;
    int         checks = 0;
    int         failures = 0;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [7:0]  e;

    always #5 aclk = ~aclk;

    axi_lite_counter_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) s_axi ();

    axi_lite_counter #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axi     (s_axi),
        .count_out (count_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge aclk);
        s_axi.awaddr  = addr;
        s_axi.wdata   = data;
        s_axi.wstrb   = strb;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        n = 0;
        while (!s_axi.awready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("awready", {31'b0, s_axi.awready}, 32'd1);
        check("wready", {31'b0, s_axi.wready}, 32'd1);
        @(negedge aclk);
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        check("bvalid", {31'b0, s_axi.bvalid}, 32'd1);
        check("bresp", {30'b0, s_axi.bresp}, 32'd0);
        @(negedge aclk);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        @(negedge aclk);
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        n = 0;
        while (!s_axi.arready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check("arready", {31'b0, s_axi.arready}, 32'd1);
        @(negedge aclk);
        s_axi.arvalid = 1'b0;
        check("rvalid", {31'b0, s_axi.rvalid}, 32'd1);
        data = s_axi.rdata;
        resp = s_axi.rresp;
        @(negedge aclk);
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axi.awaddr  = '0;
        s_axi.awprot  = '0;
        s_axi.awvalid = 1'b0;
        s_axi.wdata   = '0;
        s_axi.wstrb   = '0;
        s_axi.wvalid  = 1'b0;
        s_axi.bready  = 1'b1;
        s_axi.araddr  = '0;
        s_axi.arprot  = '0;
        s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b1;

        // Reset state
        repeat (10) @(negedge aclk);
        check("rst_count", count_out, 32'h00);
        check("rst_awready", {31'b0, s_axi.awready}, 32'd0);
        check("rst_bvalid", {31'b0, s_axi.bvalid}, 32'd0);
        check("rst_arready", {31'b0, s_axi.arready}, 32'd0);
        check("rst_rvalid", {31'b0, s_axi.rvalid}, 32'd0);
        aresetn = 1'b1;
        axi_read(4'h0, rd, rr); check("rst_ctrl", rd, 32'h0);
        axi_read(4'h4, rd, rr); check("rst_start", rd, 32'h0);
        axi_read(4'h8, rd, rr); check("rst_scratch", rd, 32'h0);
        axi_read(4'hC, rd, rr); check("rst_id", rd, 32'hABCD_1234);
        check("rst_id_rresp", {30'b0, rr}, 32'd0);

        // Load and readback while counting up
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'hC0, 4'hF);
        check("load_c0", count_out, 32'hC0);
        @(negedge aclk); check("inc_c1", count_out, 32'hC1);
        @(negedge aclk); check("inc_c2", count_out, 32'hC2);
        axi_read(4'h4, rd, rr); check("start_rb", rd, 32'h0000_00C0);

        // Enable / disable
        axi_write(4'h4, 32'hAF, 4'hF);
        check("load_af", count_out, 32'hAF);
        axi_write(4'h0, 32'h0, 4'hF);
        check("frozen", count_out, 32'hB2);
        @(negedge aclk); check("frozen_hold", count_out, 32'hB2);
        axi_write(4'h0, 32'h1, 4'hF);
        check("resume_b3", count_out, 32'hB3);
        @(negedge aclk); check("resume_b4", count_out, 32'hB4);

        // Decrement through zero
        axi_write(4'h0, 32'h3, 4'hF);
        axi_write(4'h4, 32'h11, 4'hF);
        for (int i = 0; i < 19; i++) begin
            e = 8'h11 - 8'(i);
            check("dec_wrap", count_out, {24'b0, e});
            @(negedge aclk);
        end

        // Increment wrap
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'hFE, 4'hF);
        check("inc_fe", count_out, 32'hFE);
        @(negedge aclk); check("inc_ff", count_out, 32'hFF);
        @(negedge aclk); check("inc_00", count_out, 32'h00);

        // ID register is read-only
        axi_read(4'hC, rd, rr); check("id", rd, 32'hABCD_1234);
        check("id_rresp", {30'b0, rr}, 32'd0);
        axi_write(4'hC, 32'h0, 4'hF);
        axi_read(4'hC, rd, rr); check("id_after_wr", rd, 32'hABCD_1234);

        // Byte strobes; a partial START write still reloads START[7:0]
        axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'h8, 32'h1234_5678, 4'h5);
        axi_read(4'h8, rd, rr); check("scratch_strb", rd, 32'hFF34_FF78);
        axi_write(4'h0, 32'hDEAD_BEE0, 4'hF);
        axi_read(4'h0, rd, rr); check("ctrl_upper", rd, 32'hDEAD_BEE0);
        axi_write(4'h4, 32'h0000_AB00, 4'h2);
        check("strb_load", count_out, 32'hFE);
        @(negedge aclk); check("strb_hold", count_out, 32'hFE);
        axi_read(4'h4, rd, rr); check("start_strb", rd, 32'h0000_ABFE);

        // Mid-run reset
        axi_write(4'h0, 32'h1, 4'hF);
        @(negedge aclk);
        aresetn = 1'b0;
        #1 check("async_rst", count_out, 32'h00);
        repeat (10) @(negedge aclk);
        aresetn = 1'b1;
        check("mid_rst_count", count_out, 32'h00);
        check("mid_rst_rvalid", {31'b0, s_axi.rvalid}, 32'd0);
        axi_write(4'h0, 32'h1, 4'hF);
        check("post_rst_1", count_out, 32'h01);
        axi_read(4'h4, rd, rr); check("post_rst_start", rd, 32'h0);
        check("post_rst_5", count_out, 32'h05);
        @(negedge aclk); check("post_rst_6", count_out, 32'h06);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_lite_counter.md
# axi_lite_counter

- 8-bit up/down counter with an AXI4-Lite slave register interface.
- A bus master enables the counter, selects direction and loads a start value through memory-mapped registers.
- The counter value drives a dedicated output.
- Sits behind the system AXI interconnect at base 0x44A0_0000; the block decodes only the low address bits.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32)
- C_S_AXI_ADDR_WIDTH, 4, AXI byte-address width decoded by the block
- aclk  in  1  single clock for bus and counter
- aresetn  in  1  reset, asynchronous and active-low
- s_axi_awaddr  in  4  write address; s_axi_awprot in 3 (ignored); s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata  in  32; s_axi_wstrb in 4 byte enables; s_axi_wvalid in 1; s_axi_wready out 1
- s_axi_bresp  out  2; s_axi_bvalid out 1; s_axi_bready in 1
- s_axi_araddr  in  4; s_axi_arprot in 3 (ignored); s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rdata  out  32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1
- count_out  out  8  current counter value

## Operation
- Register map (byte offset, word aligned, addr[3:2] selects):
  - 0x0 CTRL, RW. Bit0 = enable (1 counts). Bit1 = direction (0 increment, 1 decrement). Bits 31:2 are stored and read back, no function.
  - 0x4 START, RW. Bits 7:0 = load value; all 32 bits stored and read back.
  - 0x8 SCRATCH, RW. No function.
  - 0xC ID, RO. Reads constant 0xABCD_1234; writes ignored but still acknowledged OKAY.
- Writes honour wstrb per byte.
- Any completed write to START, with any strobe, loads START[7:0] (value after strobe merge) into the counter.
  - The load happens on the clock edge after the register update.
  - The load occurs regardless of enable.
- Counter update each clock, in priority order:
  1. Pending load: counter takes the load value.
  2. Else, if enable = 1: counter +1 (dir = 0) or -1 (dir = 1), modulo 256.
  3. Else: hold.
- Wrap-around: 0xFF+1 → 0x00; 0x00-1 → 0xFF.
- Changing direction or enable takes effect on the first clock after the CTRL register updates.
- bresp and rresp are always 2'b00 (OKAY).

## Timing
- Reset (aresetn low, asynchronous assert, release sampled on aclk) clears:
  - all RW registers to 0;
  - counter, so count_out = 0x00;
  - all ready/valid outputs to 0.
- Write channel:
  - awready and wready pulse high together for one cycle once awvalid and wvalid are both high and bvalid is low.
  - The register updates on that same edge.
  - bvalid rises on the next cycle and holds until bready.
  - No new write is accepted while bvalid is high.
- Read channel:
  - arready pulses one cycle when arvalid is high and rvalid is low.
  - rvalid and rdata appear on the next cycle and hold stable until rready.
- Read latency: 1 cycle after the address handshake.
- Write-to-count_out latency for a START load: 2 cycles after the write handshake edge.
- Simultaneous read and write are permitted and serviced independently. A read of a register written in the same cycle returns the old value.
- Reset asserted mid-transaction aborts it; no response is issued after reset.

## Test plan
- Reset: hold aresetn low 100 ns → count_out = 0x00; reads of CTRL, START and SCRATCH return 0; ID reads 0xABCD_1234.
- Load/readback: write CTRL = 0x1, then START = 0xC0 → read START returns 0x0000_00C0; count_out shows 0xC0 and then increments by 1 per clock.
- Enable/disable: write START = 0xAF, then CTRL = 0x0 → count_out freezes; write CTRL = 0x1 → counting resumes from the frozen value.
- Decrement and wrap: write CTRL = 0x3, START = 0x11 → count_out reaches 0x11, decrements to 0x00, then 0xFF. In increment mode, START = 0xFE → 0xFE, 0xFF, 0x00.
- ID register: read 0xC → 0xABCD_1234 with rresp OKAY; write 0xC = 0 → subsequent read is still 0xABCD_1234.
- Mid-run reset: pulse aresetn low for 100 ns while counting → count_out = 0; write CTRL = 0x1, read START → 0x0000_0000; counter increments from 0.
